// File: rtl/user_wb_arbiter.sv
// user_wb_arbiter
//   Two-master Wishbone arbiter for the user-project slave bus.
//   m0 = management core, m1 = DMA engine. Round-robin grant, held for a
//   whole cyc. A per-strobe watchdog returns a bus error when a slave never
//   acks, so a hung or unmapped peripheral cannot lock the bus.
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_*/m1_*                 master ports (cyc/stb/we/sel/adr/dat in,
//                             dat/ack/err out)
//   s_*                       shared slave bus
//   grant_o                   one-hot owner, 00 = idle
//   timeout_o                 high in the cycle the watchdog fires
module user_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // TW collapses to 0 when the watchdog is disabled; keep a 1-bit counter
  // so the declarations stay legal, and hold it at zero in that case.
  localparam int CW = (TW < 1) ? 1 : TW;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last_owner, last_nxt;
  logic [CW-1:0] wd_cnt, wd_nxt;

  logic req0, req1;
  logic own0, own1, active;
  logic cyc_n, stb_n, we_n;
  logic [3:0]  sel_n;
  logic [31:0] adr_n, dat_n;
  logic wd_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Outputs are gated by reset too, so nothing leaks out while the
  // reset cycle is in progress.
  assign own0   = (state == OWN0) & ~wb_rst_i;
  assign own1   = (state == OWN1) & ~wb_rst_i;
  assign active = own0 | own1;

  // Owner's request lines.
  assign cyc_n = own1 ? m1_cyc_i : m0_cyc_i;
  assign stb_n = own1 ? m1_stb_i : m0_stb_i;
  assign we_n  = own1 ? m1_we_i  : m0_we_i;
  assign sel_n = own1 ? m1_sel_i : m0_sel_i;
  assign adr_n = own1 ? m1_adr_i : m0_adr_i;
  assign dat_n = own1 ? m1_dat_i : m0_dat_i;

  // Watchdog fires in the cycle the counter reaches its limit with the
  // strobe still un-acked; an ack in the same cycle takes precedence.
  assign wd_hit = WD_EN & active & stb_n & ~s_ack_i & (wd_cnt == LIMIT);

  // Slave bus
  assign s_cyc_o = active & cyc_n;
  assign s_stb_o = active & stb_n & ~wd_hit;
  assign s_we_o  = active & we_n;
  assign s_sel_o = active ? sel_n : 4'd0;
  assign s_adr_o = active ? adr_n : 32'd0;
  assign s_dat_o = active ? dat_n : 32'd0;

  // Master responses: only the owner sees anything.
  assign m0_ack_o  = own0 & s_ack_i;
  assign m1_ack_o  = own1 & s_ack_i;
  assign m0_err_o  = own0 & wd_hit;
  assign m1_err_o  = own1 & wd_hit;
  assign m0_dat_o  = own0 ? s_dat_i : 32'd0;
  assign m1_dat_o  = own1 ? s_dat_i : 32'd0;
  assign grant_o   = {own1, own0};
  assign timeout_o = wd_hit;

  // Next state. Handover always passes through IDLE, which gives the one
  // idle bus cycle between owners and keeps arbitration in one place.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
        if (state_nxt == OWN0) last_nxt = 1'b0;
        if (state_nxt == OWN1) last_nxt = 1'b1;
      end
      OWN0:    if (!m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wd_nxt = '0;
    if (WD_EN && active && stb_n && !s_ack_i && !wd_hit)
      wd_nxt = wd_cnt + CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      wd_cnt     <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_user_wb_arbiter.sv
// tb_user_wb_arbiter
//   Directed walk through the arbitration / watchdog scenarios followed by
//   random traffic. A transaction-level model (owner, last owner, count of
//   un-acked strobe cycles) predicts every output each cycle.
module tb_user_wb_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        timeout;

  int vectors = 0;
  int errors  = 0;

  // model state: owner 0 = none, 1 = m0, 2 = m1
  int  mo = 0;
  int  ml = 1;
  int  mw = 0;
  bit  mfire;

  always #5 clk = ~clk;

  user_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drv(input bit r, input bit c0, input bit s0,
                     input bit c1, input bit s1, input bit a);
    rst = r; m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = a;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_sel = 4'($urandom); m1_sel = 4'($urandom);
    m0_adr = $urandom; m1_adr = $urandom;
    m0_wdat = $urandom; m1_wdat = $urandom;
    s_rdat = $urandom;
  endtask

  // Check every output against the model, then clock and advance the model.
  task automatic step();
    bit act, cy, sb, we;
    logic [3:0]  sl;
    logic [31:0] ad, dt;
    #1;
    act = !rst && mo != 0;
    cy = (mo == 2) ? m1_cyc : m0_cyc;
    sb = (mo == 2) ? m1_stb : m0_stb;
    we = (mo == 2) ? m1_we  : m0_we;
    sl = (mo == 2) ? m1_sel : m0_sel;
    ad = (mo == 2) ? m1_adr : m0_adr;
    dt = (mo == 2) ? m1_wdat : m0_wdat;
    mfire = act && T > 0 && sb && !s_ack && mw == T - 1;
    chk("s_ctl", {s_cyc, s_stb, s_we, s_sel},
        act ? {cy, sb && !mfire, we, sl} : 7'd0);
    chk("s_adr", s_adr, act ? ad : 32'd0);
    chk("s_dat", s_wdat, act ? dt : 32'd0);
    chk("m0_resp", {m0_ack, m0_err}, (act && mo == 1) ? {s_ack, mfire} : 2'b00);
    chk("m1_resp", {m1_ack, m1_err}, (act && mo == 2) ? {s_ack, mfire} : 2'b00);
    chk("m0_dat", m0_rdat, (act && mo == 1) ? s_rdat : 32'd0);
    chk("m1_dat", m1_rdat, (act && mo == 2) ? s_rdat : 32'd0);
    chk("grant", grant, act ? ((mo == 1) ? 2'b01 : 2'b10) : 2'b00);
    chk("timeout", timeout, mfire);
    @(posedge clk);
    if (rst) begin
      mo = 0; ml = 1; mw = 0;
    end else if (mo == 0) begin
      mw = 0;
      if ((m0_cyc && m0_stb) && (m1_cyc && m1_stb)) mo = (ml == 1) ? 1 : 2;
      else if (m0_cyc && m0_stb)                    mo = 1;
      else if (m1_cyc && m1_stb)                    mo = 2;
      if (mo != 0) ml = mo - 1;
    end else begin
      mw = (sb && !s_ack && !mfire) ? mw + 1 : 0;
      if (!cy) mo = 0;
    end
    #1;
  endtask

  initial begin
    // reset, single m0 read with ack two cycles after the strobe
    drv(1, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 0); step();
    drv(0, 1, 1, 0, 0, 0); m0_adr = 32'h3004_0000;
    #1 chk("rst_grant", grant, 2'b00); chk("arb_latency", s_cyc, 1'b0);
    step();
    drv(0, 1, 1, 0, 0, 0); m0_adr = 32'h3004_0000;
    #1 chk("own0_grant", grant, 2'b01); chk("own0_scyc", s_cyc, 1'b1);
    chk("own0_adr", s_adr, 32'h3004_0000);
    step();
    drv(0, 1, 1, 0, 0, 0); m0_adr = 32'h3004_0000; step();
    drv(0, 1, 1, 0, 0, 1); m0_adr = 32'h3004_0000; s_rdat = 32'h1234_5678;
    #1 chk("rd_ack", m0_ack, 1'b1); chk("rd_dat", m0_rdat, 32'h1234_5678);
    chk("rd_m1ack", m1_ack, 1'b0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("ack_one_cycle", m0_ack, 1'b0);
    step();

    // simultaneous requests after reset: m0, gap, m1, then m0 again
    drv(1, 0, 0, 0, 0, 0); step();
    drv(0, 1, 1, 1, 1, 0); step();
    drv(0, 1, 1, 1, 1, 1);
    #1 chk("both_first", grant, 2'b01); chk("both_m1ack", m1_ack, 1'b0);
    step();
    drv(0, 0, 0, 1, 1, 0); step();
    drv(0, 0, 0, 1, 1, 0);
    #1 chk("idle_gap", grant, 2'b00);
    step();
    drv(0, 0, 0, 1, 1, 1);
    #1 chk("second_owner", grant, 2'b10);
    step();
    drv(0, 0, 0, 0, 0, 0); step();
    drv(0, 1, 1, 1, 1, 0); step();
    drv(0, 0, 0, 1, 1, 0);
    #1 chk("alternate", grant, 2'b01);
    step();
    drv(0, 0, 0, 0, 0, 0); step();

    // watchdog on m1: error on the 4th un-acked strobe cycle
    drv(0, 0, 0, 1, 1, 0); step();
    for (int k = 1; k <= 4; k++) begin
      drv(0, 0, 0, 1, 1, 0);
      #1;
      if (k < 4) chk("wd_early", {m1_err, timeout}, 2'b00);
      else begin
        chk("wd_err", m1_err, 1'b1); chk("wd_pulse", timeout, 1'b1);
        chk("wd_stb", s_stb, 1'b0);  chk("wd_m0err", m0_err, 1'b0);
      end
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("wd_after", timeout, 1'b0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("wd_idle", grant, 2'b00);
    step();

    // ack on the 4th strobe cycle beats the watchdog
    drv(0, 1, 1, 0, 0, 0); step();
    for (int k = 1; k <= 4; k++) begin
      drv(0, 1, 1, 0, 0, k == 4);
      #1;
      if (k == 4) begin
        chk("race_ack", m0_ack, 1'b1); chk("race_err", m0_err, 1'b0);
        chk("race_to", timeout, 1'b0);
      end
      step();
    end
    drv(0, 0, 0, 0, 0, 0); step();

    // m1 burst with m0 waiting: no preemption
    drv(0, 1, 1, 1, 1, 0); step();
    for (int k = 0; k < 3; k++) begin
      drv(0, 1, 1, 1, 1, 1);
      #1 chk("burst_grant", grant, 2'b10); chk("burst_ack", m1_ack, 1'b1);
      chk("burst_m0ack", m0_ack, 1'b0);
      step();
    end
    drv(0, 1, 1, 0, 0, 0); step();
    drv(0, 1, 1, 0, 0, 0);
    #1 chk("burst_gap", grant, 2'b00);
    step();
    drv(0, 1, 1, 0, 0, 0);
    #1 chk("burst_next", grant, 2'b01);
    step();

    // reset in the middle of an m0 transfer
    drv(1, 1, 1, 0, 0, 1); step();
    drv(0, 1, 1, 1, 1, 1);
    #1 chk("mid_rst_out", {grant, s_cyc, s_stb, m0_ack, m0_err, timeout}, 7'd0);
    step();
    drv(0, 1, 1, 1, 1, 0);
    #1 chk("mid_rst_arb", grant, 2'b01);
    step();

    // random traffic
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit c0, c1, r;
      r  = ($urandom % 64) == 0;
      c0 = m0_cyc ? (($urandom % 6) != 0) : (($urandom % 3) == 0);
      c1 = m1_cyc ? (($urandom % 6) != 0) : (($urandom % 3) == 0);
      drv(r, c0, c0 && ($urandom % 4 != 0), c1, c1 && ($urandom % 4 != 0),
          ($urandom % 3) == 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
